la_playback: RTL and testbench

LA_PLAYBACK -- requirements
Module: la_playback

---
 rtl/la_playback_pkg.sv | 44 ++++
 rtl/la_playback_tick_gen.sv | 27 ++
 rtl/la_playback.sv | 115 +++++++++++
 tb/tb_la_playback.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_playback_pkg.sv
// Shared definitions for logic-analyser playback and capture: FSM states, config layout, rate table.
// Rate table entries are tick-counter terminal counts; the sample period is N+1 clocks.
package la_playback_pkg;

  localparam int CNT_W        = 12;
  localparam int CFG_EN_BIT   = 0;
  localparam int CFG_RATE_LSB = 4;
  localparam int CFG_RATE_W   = 3;

  localparam logic [CNT_W-1:0] RATE_N0 = 12'd0;
  localparam logic [CNT_W-1:0] RATE_N1 = 12'd2603;
  localparam logic [CNT_W-1:0] RATE_N2 = 12'd1301;
  localparam logic [CNT_W-1:0] RATE_N3 = 12'd868;
  localparam logic [CNT_W-1:0] RATE_N4 = 12'd521;
  localparam logic [CNT_W-1:0] RATE_N5 = 12'd260;
  localparam logic [CNT_W-1:0] RATE_N6 = 12'd130;
  localparam logic [CNT_W-1:0] RATE_N7 = 12'd87;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PLAY,
    ST_STALL
  } state_t;

  typedef struct packed {
    logic [CFG_RATE_W-1:0] rate;
    logic                  en;
  } cfg_t;

  function automatic logic [CNT_W-1:0] rate_to_n(input logic [CFG_RATE_W-1:0] sel);
    case (sel)
      3'd1:    rate_to_n = RATE_N1;
      3'd2:    rate_to_n = RATE_N2;
      3'd3:    rate_to_n = RATE_N3;
      3'd4:    rate_to_n = RATE_N4;
      3'd5:    rate_to_n = RATE_N5;
      3'd6:    rate_to_n = RATE_N6;
      3'd7:    rate_to_n = RATE_N7;
      default: rate_to_n = RATE_N0;
    endcase
  endfunction

endpackage

// File: rtl/la_playback_tick_gen.sv
// Sample-rate tick generator: counts 0..n and pulses tick for one cycle at n (period n+1); n=0 never ticks.
// Latency: first tick n+1 clocks after clear drops; no backpressure, clear restarts the count.
module la_tick_gen
  import la_playback_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] n,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && (n != '0) && (cnt == n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick || (n == '0)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/la_playback.sv
// Replays packed 2-channel capture bytes from a FIFO, one sample per rate tick; first sample N+1 clocks after a byte is primed.
// Backpressure: one-byte prefetch with one outstanding read; an empty FIFO at a byte boundary stalls and sets sticky underrun.
module la_playback
  import la_playback_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    config_valid,
  input  logic [7:0]              config_in,
  input  logic [7:0]              fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_ren,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    busy,
  output logic                    underrun
);

  state_t     state;
  cfg_t       cfg_r;
  logic [7:0] cur;
  logic [7:0] nxt;
  logic       cur_v;
  logic       nxt_v;
  logic       rd_pend;
  logic [1:0] k;
  logic       enabled;
  logic       restart;
  logic       tick;
  logic       cfg_unused;

  assign cfg_unused = ^{config_in[7], config_in[3:1]};

  assign enabled  = cfg_r.en && (cfg_r.rate != '0);
  assign restart  = ((state == ST_PRIME) || (state == ST_STALL)) && nxt_v;
  assign busy     = (state != ST_IDLE);
  // Read is withheld on a config strobe so no byte is fetched only to be flushed.
  assign fifo_ren = enabled && (state != ST_IDLE) && !nxt_v && !rd_pend
                    && !fifo_empty && !config_valid;

  la_tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state == ST_IDLE) || config_valid || restart),
    .n     (rate_to_n(cfg_r.rate)),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cfg_r    <= '0;
      dout     <= '0;
      underrun <= 1'b0;
      cur      <= '0;
      cur_v    <= 1'b0;
      nxt      <= '0;
      nxt_v    <= 1'b0;
      rd_pend  <= 1'b0;
      k        <= '0;
    end else if (config_valid) begin
      cfg_r    <= '{rate: config_in[CFG_RATE_LSB +: CFG_RATE_W], en: config_in[CFG_EN_BIT]};
      state    <= ST_IDLE;
      underrun <= 1'b0;
      cur_v    <= 1'b0;
      nxt_v    <= 1'b0;
      rd_pend  <= 1'b0;
      k        <= '0;
    end else if (!enabled) begin
      state   <= ST_IDLE;
      cur_v   <= 1'b0;
      nxt_v   <= 1'b0;
      rd_pend <= 1'b0;
      k       <= '0;
    end else begin
      rd_pend <= fifo_ren;
      if (rd_pend) begin
        nxt   <= fifo_rdata;
        nxt_v <= 1'b1;
      end
      // A load in the same cycle as a capture takes the old nxt; nxt_v then reflects the refill.
      case (state)
        ST_IDLE: state <= ST_PRIME;
        ST_PRIME, ST_STALL: begin
          if (nxt_v) begin
            cur   <= nxt;
            cur_v <= 1'b1;
            nxt_v <= rd_pend;
            k     <= '0;
            state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick && cur_v) begin
            dout <= {cur[{1'b1, ~k}], cur[{1'b0, ~k}]};
            k    <= k + 2'd1;
            if (k == 2'd3) begin
              if (nxt_v) begin
                cur   <= nxt;
                nxt_v <= rd_pend;
              end else begin
                cur_v    <= 1'b0;
                underrun <= 1'b1;
                state    <= ST_STALL;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_playback.sv
// Bench for la_playback: FIFO responder, schedule-level reference model checked every cycle, plus literal scenarios.
module tb_la_playback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       config_valid;
  logic [7:0] config_in;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_ren;
  logic [1:0] dout;
  logic       busy;
  logic       underrun;

  always #5 clk = ~clk;

  la_playback #(.OUTPUT_WIDTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .config_valid (config_valid),
    .config_in    (config_in),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_ren     (fifo_ren),
    .dout         (dout),
    .busy         (busy),
    .underrun     (underrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int ren_count = 0;
  logic pop_due = 1'b0;
  logic [7:0] fifo_q[$];

  // Reference model: which bytes have been fetched, when each becomes usable, and when the next step is due.
  typedef enum {M_IDLE, M_WAIT, M_PLAY} mmode_t;
  mmode_t     m_mode;
  logic       m_en_bit;
  logic [2:0] m_rate;
  logic [7:0] m_cur;
  int         m_left;
  int         m_next;
  logic [7:0] mq_byte[$];
  int         mq_avail[$];
  logic [1:0] m_dout;
  logic       m_und;

  logic [1:0] last_dout = 2'b00;
  logic [1:0] chg_val[$];
  int         chg_cyc[$];

  function automatic int rate_n(input logic [2:0] r);
    case (r)
      3'd1: return 2603;
      3'd2: return 1301;
      3'd3: return 868;
      3'd4: return 521;
      3'd5: return 260;
      3'd6: return 130;
      3'd7: return 87;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] sample(input logic [7:0] b, input int idx);
    logic [1:0] s;
    s[0] = b[3-idx];
    s[1] = b[7-idx];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_en_bit = 1'b0;
    m_rate = 3'd0;
    m_cur = 8'h00;
    m_left = 0;
    m_next = 0;
    mq_byte.delete();
    mq_avail.delete();
    m_dout = 2'b00;
    m_und = 1'b0;
  endtask

  task automatic model_edge(input int e, input logic ren);
    logic [7:0] b;
    b = 8'h00;
    if (ren) b = fifo_q[0];
    if (config_valid) begin
      m_en_bit = config_in[0];
      m_rate = config_in[6:4];
      m_mode = M_IDLE;
      mq_byte.delete();
      mq_avail.delete();
      m_left = 0;
      m_und = 1'b0;
    end else if (!(m_en_bit && m_rate != 3'd0)) begin
      m_mode = M_IDLE;
      mq_byte.delete();
      mq_avail.delete();
      m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_WAIT;
        M_WAIT: begin
          if (mq_byte.size() != 0 && mq_avail[0] <= e) begin
            m_cur = mq_byte.pop_front();
            void'(mq_avail.pop_front());
            m_left = 4;
            m_next = e + rate_n(m_rate) + 1;
            m_mode = M_PLAY;
          end
        end
        default: begin
          if (e == m_next) begin
            m_dout = sample(m_cur, 4 - m_left);
            m_left--;
            m_next = e + rate_n(m_rate) + 1;
            if (m_left == 0) begin
              if (mq_byte.size() != 0 && mq_avail[0] <= e) begin
                m_cur = mq_byte.pop_front();
                void'(mq_avail.pop_front());
                m_left = 4;
              end else begin
                m_mode = M_WAIT;
                m_und = 1'b1;
              end
            end
          end
        end
      endcase
    end
    // A read strobed before edge e returns data for edge e+1 and can be consumed from edge e+2.
    if (ren) begin
      mq_byte.push_back(b);
      mq_avail.push_back(e + 2);
    end
  endtask

  task automatic cyc();
    logic exp_ren;
    @(negedge clk);
    if (dout !== last_dout) begin
      chg_val.push_back(dout);
      chg_cyc.push_back(cyc_n);
      last_dout = dout;
    end
    if (!rst_n) model_reset();
    check("dout", {30'd0, dout}, {30'd0, m_dout});
    check("busy", {31'd0, busy}, {31'd0, m_mode != M_IDLE});
    check("underrun", {31'd0, underrun}, {31'd0, m_und});
    check("ren_on_empty", {31'd0, fifo_ren & fifo_empty}, 32'd0);
    exp_ren = rst_n && m_en_bit && (m_rate != 3'd0) && (m_mode != M_IDLE)
              && (mq_byte.size() == 0) && (fifo_q.size() != 0) && !config_valid;
    check("fifo_ren", {31'd0, fifo_ren}, {31'd0, exp_ren});
    if (fifo_ren) ren_count++;
    pop_due = fifo_ren && (fifo_q.size() != 0);
    if (rst_n) model_edge(cyc_n + 1, exp_ren);
    @(posedge clk);
    #1;
    cyc_n++;
    if (pop_due) fifo_rdata = fifo_q.pop_front();
    else fifo_rdata = 8'($urandom);
    fifo_empty = (fifo_q.size() == 0);
    config_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic configure(input logic [7:0] c);
    config_valid = 1'b1;
    config_in = c;
  endtask

  task automatic clear_log();
    chg_val.delete();
    chg_cyc.delete();
  endtask

  int c0;
  logic [2:0] rsel;

  initial begin
    rst_n = 1'b0;
    config_valid = 1'b0;
    config_in = 8'h00;
    fifo_rdata = 8'h00;
    fifo_empty = 1'b1;
    model_reset();
    repeat (3) cyc();
    check("rst_dout", {30'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_ren", {31'd0, fifo_ren}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Empty FIFO at enable; reserved config bits set to show they are ignored.
    configure(8'hFF);
    repeat (40) cyc();
    check("prime_busy", {31'd0, busy}, 32'd1);
    check("prime_ren", {31'd0, fifo_ren}, 32'd0);
    check("prime_dout", {30'd0, dout}, 32'd0);
    clear_log();
    c0 = cyc_n;
    push(8'hFF);
    repeat (120) cyc();
    check("ff_nchg", chg_val.size(), 32'd1);
    if (chg_val.size() == 1) begin
      check("ff_val", {30'd0, chg_val[0]}, 32'd3);
      check("ff_time", chg_cyc[0] - c0, 32'd91);
    end

    // Rate 7, single byte 0xA5, then underrun stall.
    configure(8'h71);
    push(8'hA5);
    clear_log();
    c0 = cyc_n;
    repeat (400) cyc();
    check("a5_nchg", chg_val.size(), 32'd4);
    if (chg_val.size() == 4) begin
      check("a5_v0", {30'd0, chg_val[0]}, 32'd2);
      check("a5_v1", {30'd0, chg_val[1]}, 32'd1);
      check("a5_v2", {30'd0, chg_val[2]}, 32'd2);
      check("a5_v3", {30'd0, chg_val[3]}, 32'd1);
      for (int i = 0; i < 4; i++)
        check($sformatf("a5_t%0d", i), chg_cyc[i] - c0, 93 + 88 * i);
    end
    check("a5_underrun", {31'd0, underrun}, 32'd1);
    check("a5_busy", {31'd0, busy}, 32'd1);
    check("a5_hold", {30'd0, dout}, 32'd1);

    // Recovery from STALL: underrun stays sticky until a config strobe.
    clear_log();
    c0 = cyc_n;
    push(8'h5A);
    repeat (400) cyc();
    check("5a_nchg", chg_val.size(), 32'd3);
    if (chg_val.size() == 3) begin
      check("5a_v0", {30'd0, chg_val[0]}, 32'd2);
      check("5a_v2", {30'd0, chg_val[2]}, 32'd2);
      check("5a_t0", chg_cyc[0] - c0, 32'd179);
    end
    check("5a_underrun", {31'd0, underrun}, 32'd1);
    configure(8'h71);
    cyc();
    check("cfg_clr_underrun", {31'd0, underrun}, 32'd0);

    // Rate 6, two preloaded bytes back to back.
    configure(8'h00);
    cyc();
    push(8'h0F);
    push(8'hF0);
    configure(8'h61);
    clear_log();
    c0 = cyc_n;
    repeat (1100) cyc();
    check("r6_nchg", chg_val.size(), 32'd2);
    if (chg_val.size() == 2) begin
      check("r6_v0", {30'd0, chg_val[0]}, 32'd1);
      check("r6_v1", {30'd0, chg_val[1]}, 32'd2);
      check("r6_t0", chg_cyc[0] - c0, 32'd136);
      check("r6_t1", chg_cyc[1] - c0, 32'd660);
    end
    check("r6_underrun", {31'd0, underrun}, 32'd1);

    // Disable mid-byte: idle at once, dout held, no more reads.
    push(8'hA5);
    configure(8'h61);
    repeat (300) cyc();
    check("dis_pre_dout", {30'd0, dout}, 32'd1);
    configure(8'h00);
    push(8'hCC);
    cyc();
    check("dis_busy", {31'd0, busy}, 32'd0);
    ren_count = 0;
    repeat (200) cyc();
    check("dis_ren", ren_count, 32'd0);
    check("dis_dout", {30'd0, dout}, 32'd1);

    // Asynchronous reset mid-play.
    configure(8'h71);
    repeat (150) cyc();
    check("pre_rst_dout", {30'd0, dout}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", {30'd0, dout}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ren", {31'd0, fifo_ren}, 32'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    push(8'h77);
    ren_count = 0;
    repeat (200) cyc();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_ren", ren_count, 32'd0);

    // Randomized traffic and reconfiguration.
    configure(8'h51);
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 199) == 0 && fifo_q.size() < 8) push(8'($urandom));
      if ($urandom_range(0, 2999) == 0) begin
        case ($urandom_range(0, 4))
          0: rsel = 3'd0;
          1: rsel = 3'd4;
          2: rsel = 3'd5;
          3: rsel = 3'd6;
          default: rsel = 3'd7;
        endcase
        config_in = 8'($urandom);
        config_in[6:4] = rsel;
        config_in[0] = ($urandom_range(0, 9) != 0);
        config_valid = 1'b1;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
